// File: rtl/mul_shift_unit.sv
// mul_shift_unit: multi-cycle multiply / shift / rotate unit.
//   A START in IDLE latches the operands and the operation, then one step is
//   performed per RUN cycle (shift-add multiply, or a 1-bit shift/rotate).
//   The result is written once, on entry to DONE, and held until the next
//   accepted START.
// Ports:
//   CLK    in   rising-edge clock
//   RESET  in   asynchronous active-high reset
//   DATA1  in   [7:0] operand A (multiplicand / value to shift)
//   DATA2  in   [7:0] operand B (multiplier / shift amount)
//   SELECT in   [2:0] 000 MUL, 001 SLL, 010 SRL, 011 SRA, 100 ROR, others reserved
//   START  in   request, only sampled in IDLE
//   RESULT out  [7:0] registered result
//   BUSY   out  combinational stall: (IDLE and START) or RUN
//   DONE   out  high for the single DONE-state cycle
module mul_shift_unit (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  input  logic [2:0] SELECT,
  input  logic       START,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_MUL = 3'b000,
    OP_SLL = 3'b001,
    OP_SRL = 3'b010,
    OP_SRA = 3'b011,
    OP_ROR = 3'b100
  } op_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  op_q;
  logic [7:0]  val_q;     // shifted operand / shifted multiplicand
  logic [7:0]  mplr_q;    // multiplier, consumed LSB first
  logic [7:0]  acc_q;     // partial product (low 8 bits suffice)
  logic [3:0]  cnt_q;
  logic [7:0]  result_q;

  logic [3:0]  start_cnt;
  logic        start_valid;
  logic [7:0]  val_step;
  logic [7:0]  acc_step;

  // Step count for the operation being offered on the inputs.
  always_comb begin
    start_cnt   = '0;
    start_valid = 1'b1;
    case (SELECT)
      OP_MUL:                 start_cnt = 4'd8;
      OP_SLL, OP_SRL, OP_SRA: start_cnt = (DATA2 > 8'd8) ? 4'd8 : DATA2[3:0];
      OP_ROR:                 start_cnt = {1'b0, DATA2[2:0]};
      default: begin
        start_cnt   = '0;
        start_valid = 1'b0;
      end
    endcase
  end

  // One step of the latched operation. MUL shares the left shift of the
  // multiplicand with SLL.
  always_comb begin
    val_step = val_q;
    case (op_q)
      OP_MUL, OP_SLL: val_step = {val_q[6:0], 1'b0};
      OP_SRL:         val_step = {1'b0, val_q[7:1]};
      OP_SRA:         val_step = {val_q[7], val_q[7:1]};
      OP_ROR:         val_step = {val_q[0], val_q[7:1]};
      default:        val_step = val_q;
    endcase
    acc_step = mplr_q[0] ? (acc_q + val_q) : acc_q;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (START) state_next = (start_cnt == 4'd0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q <= 4'd1) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      val_q    <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (START) begin
            op_q   <= SELECT;
            val_q  <= DATA1;
            mplr_q <= DATA2;
            acc_q  <= '0;
            cnt_q  <= start_cnt;
            if (start_cnt == 4'd0)
              result_q <= start_valid ? DATA1 : '0;
          end
        end
        ST_RUN: begin
          val_q  <= val_step;
          mplr_q <= {1'b0, mplr_q[7:1]};
          acc_q  <= acc_step;
          cnt_q  <= cnt_q - 4'd1;
          // Last step: commit straight from the step logic so RESULT
          // changes only on the transition into DONE.
          if (cnt_q <= 4'd1)
            result_q <= (op_q == OP_MUL) ? acc_step : val_step;
        end
        default: ;
      endcase
    end
  end

  assign RESULT = result_q;
  assign DONE   = (state == ST_DONE);
  assign BUSY   = !RESET && (((state == ST_IDLE) && START) || (state == ST_RUN));

endmodule
